// File: rtl/multicycle_controller_if.sv
// Control-plane bundle between fetch, the multicycle controller and the datapath.
// The controller side is the master; the surrounding fetch/datapath side is the slave.
interface multicycle_controller_if;
  logic        instr_valid;
  logic        instr_ready;
  logic [11:0] opfunc;
  logic [3:0]  alu_nzcv;
  logic        mem_ready;
  logic [3:0]  alu_op;
  logic [1:0]  alu_src;
  logic        reg_write;
  logic        mem_to_reg;
  logic        mem_read;
  logic        mem_write;
  logic        pc_src;
  logic        link;
  logic        pc_write;
  logic [3:0]  nzcv;
  logic        illegal;
  logic        fault;

  modport master (
    input  instr_valid, opfunc, alu_nzcv, mem_ready,
    output instr_ready, alu_op, alu_src, reg_write, mem_to_reg, mem_read,
           mem_write, pc_src, link, pc_write, nzcv, illegal, fault
  );

  modport slave (
    output instr_valid, opfunc, alu_nzcv, mem_ready,
    input  instr_ready, alu_op, alu_src, reg_write, mem_to_reg, mem_read,
           mem_write, pc_src, link, pc_write, nzcv, illegal, fault
  );
endinterface

// File: rtl/multicycle_controller.sv
// Multicycle control FSM for the 12-bit opfunc ISA.
// Accepts one instruction at a time from fetch, walks it through EXEC/MEM/WB,
// owns the architectural NZCV flags and flags a sticky fault on memory timeout.
module multicycle_controller #(
  parameter int         MEM_TIMEOUT = 16,
  parameter logic [3:0] NZCV_INIT   = 4'b0000,
  parameter bit         FAULT_HALT  = 1'b1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  multicycle_controller_if.master bus
);

  localparam int CW = $clog2(MEM_TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_EXEC  = 3'd1,
    S_MEM   = 3'd2,
    S_WB    = 3'd3,
    S_FAULT = 3'd4
  } state_t;

  state_t          r_state;
  state_t          w_state_next;
  logic [7:0]      r_op;
  logic            r_cond_ok;
  logic [3:0]      r_nzcv;
  logic            r_fault;
  logic [CW-1:0]   r_tmo_cnt;

  logic            w_cond_ok;
  logic            w_is_dp;
  logic            w_is_cmp;
  logic            w_is_ldst;
  logic            w_is_branch;
  logic            w_is_undef;
  logic            w_is_load;
  logic            w_tmo_hit;
  logic            w_flag_n;
  logic            w_flag_z;
  logic            w_flag_c;
  logic            w_flag_v;
  logic [3:0]      w_ls_alu_op;
  logic [1:0]      w_ls_alu_src;

  // Decode of the latched op byte only; the live opfunc is never decoded past IDLE.
  assign w_is_dp      = (r_op[7:6] == 2'b00);
  assign w_is_cmp     = (r_op[7:3] == 5'b00010);
  assign w_is_ldst    = (r_op[7:6] == 2'b01);
  assign w_is_branch  = (r_op[7:5] == 3'b101);
  assign w_is_undef   = ~(w_is_dp | w_is_ldst | w_is_branch);
  assign w_is_load    = r_op[0];
  assign w_ls_alu_op  = r_op[3] ? 4'b0100 : 4'b0010;
  assign w_ls_alu_src = r_op[5] ? 2'b10 : 2'b11;

  // Completion on the last allowed cycle wins over the timeout.
  assign w_tmo_hit = (r_tmo_cnt == CW'(MEM_TIMEOUT - 1)) && !bus.mem_ready;

  assign {w_flag_n, w_flag_z, w_flag_c, w_flag_v} = r_nzcv;

  // Condition evaluation against the registered flags, sampled when the instruction is accepted.
  always_comb begin
    w_cond_ok = 1'b1;
    case (bus.opfunc[11:8])
      4'd0:    w_cond_ok = w_flag_z;
      4'd1:    w_cond_ok = ~w_flag_z;
      4'd2:    w_cond_ok = w_flag_c;
      4'd3:    w_cond_ok = ~w_flag_c;
      4'd4:    w_cond_ok = w_flag_n;
      4'd5:    w_cond_ok = ~w_flag_n;
      4'd6:    w_cond_ok = w_flag_v;
      4'd7:    w_cond_ok = ~w_flag_v;
      4'd8:    w_cond_ok = w_flag_c & ~w_flag_z;
      4'd9:    w_cond_ok = ~w_flag_c | w_flag_z;
      4'd10:   w_cond_ok = (w_flag_n == w_flag_v);
      4'd11:   w_cond_ok = (w_flag_n != w_flag_v);
      4'd12:   w_cond_ok = ~w_flag_z & (w_flag_n == w_flag_v);
      4'd13:   w_cond_ok = w_flag_z | (w_flag_n != w_flag_v);
      default: w_cond_ok = 1'b1;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (bus.instr_valid) w_state_next = S_EXEC;
      end
      S_EXEC: begin
        if (!r_cond_ok || w_is_undef || w_is_branch) w_state_next = S_IDLE;
        else if (w_is_dp) w_state_next = w_is_cmp ? S_IDLE : S_WB;
        else w_state_next = S_MEM;
      end
      S_MEM: begin
        if (bus.mem_ready) w_state_next = w_is_load ? S_WB : S_IDLE;
        else if (w_tmo_hit) w_state_next = FAULT_HALT ? S_FAULT : S_IDLE;
      end
      S_WB:    w_state_next = S_IDLE;
      S_FAULT: w_state_next = S_FAULT;
      default: w_state_next = S_IDLE;
    endcase
  end

  // Instruction latch, flags, sticky fault and memory wait counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_op      <= 8'h00;
      r_cond_ok <= 1'b0;
      r_nzcv    <= NZCV_INIT;
      r_fault   <= 1'b0;
      r_tmo_cnt <= '0;
    end else begin
      if (r_state == S_IDLE && bus.instr_valid) begin
        r_op      <= bus.opfunc[7:0];
        r_cond_ok <= w_cond_ok;
      end
      if (r_state == S_EXEC) begin
        r_tmo_cnt <= '0;
        if (r_cond_ok && w_is_dp && r_op[0]) r_nzcv <= bus.alu_nzcv;
      end
      if (r_state == S_MEM && !bus.mem_ready) begin
        r_tmo_cnt <= r_tmo_cnt + 1'b1;
        if (w_tmo_hit) r_fault <= 1'b1;
      end
    end
  end

  // Moore outputs from state and latched op; the store pc_write pulse qualifies on mem_ready.
  always_comb begin
    bus.instr_ready = 1'b0;
    bus.alu_op      = 4'b0000;
    bus.alu_src     = 2'b00;
    bus.reg_write   = 1'b0;
    bus.mem_to_reg  = 1'b0;
    bus.mem_read    = 1'b0;
    bus.mem_write   = 1'b0;
    bus.pc_src      = 1'b0;
    bus.link        = 1'b0;
    bus.pc_write    = 1'b0;
    bus.illegal     = 1'b0;
    case (r_state)
      S_IDLE: bus.instr_ready = 1'b1;
      S_EXEC: begin
        if (!r_cond_ok || w_is_undef) begin
          bus.pc_write = 1'b1;
          bus.illegal  = r_cond_ok & w_is_undef;
        end else if (w_is_branch) begin
          bus.pc_src    = 1'b1;
          bus.pc_write  = 1'b1;
          bus.link      = r_op[4];
          bus.reg_write = r_op[4];
        end else if (w_is_dp) begin
          bus.alu_op   = r_op[4:1];
          bus.alu_src  = 2'b00;
          bus.pc_write = w_is_cmp;
        end else begin
          bus.alu_op  = w_ls_alu_op;
          bus.alu_src = w_ls_alu_src;
        end
      end
      S_MEM: begin
        bus.alu_op    = w_ls_alu_op;
        bus.alu_src   = w_ls_alu_src;
        bus.mem_read  = w_is_load;
        bus.mem_write = ~w_is_load;
        bus.pc_write  = ~w_is_load & bus.mem_ready;
      end
      S_WB: begin
        bus.reg_write  = 1'b1;
        bus.pc_write   = 1'b1;
        bus.mem_to_reg = w_is_ldst;
      end
      default: ;
    endcase
  end

  assign bus.nzcv  = r_nzcv;
  assign bus.fault = r_fault;

endmodule
